// File: rtl/otter_mem_arbiter.sv
// Shares the OTTER memory-hub port between instruction fetch and data load/store.
// Runs one downstream transaction at a time and has a watchdog for a hung memory.
module otter_mem_arbiter #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned PRIO_DATA = 1,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                ARB_CLK,
   input  logic                ARB_RESET,
   input  logic                ARB_IREQ,
   input  logic [ADDR_W-1:0]   ARB_IADDR,
   output logic [DATA_W-1:0]   ARB_IRDATA,
   output logic                ARB_IDONE,
   input  logic                ARB_DREQ,
   input  logic                ARB_DWE,
   input  logic [DATA_W/8-1:0] ARB_DBE,
   input  logic [ADDR_W-1:0]   ARB_DADDR,
   input  logic [DATA_W-1:0]   ARB_DWDATA,
   output logic [DATA_W-1:0]   ARB_DRDATA,
   output logic                ARB_DDONE,
   output logic                ARB_STALL,
   output logic                ARB_TIMEOUT,
   output logic                MEM_REQ,
   output logic                MEM_WE,
   output logic [DATA_W/8-1:0] MEM_BE,
   output logic [ADDR_W-1:0]   MEM_ADDR,
   output logic [DATA_W-1:0]   MEM_WDATA,
   input  logic [DATA_W-1:0]   MEM_RDATA,
   input  logic                MEM_ACK
);

   localparam int unsigned BE_W    = DATA_W / 8;
   localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                we_q, we_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   irdata_q, irdata_d;
   logic [DATA_W-1:0]   drdata_q, drdata_d;
   logic                idone_q, idone_d;
   logic                ddone_q, ddone_d;
   logic                last_d_q, last_d_d;
   logic                tmo_q, tmo_d;
   logic [CNT_W-1:0]    wdog_q, wdog_d;

   logic                ireq_v, dreq_v, pick_d, expire;

   // A requester whose DONE is high this cycle is not eligible for a new grant.
   assign ireq_v = ARB_IREQ & ~idone_q;
   assign dreq_v = ARB_DREQ & ~ddone_q;
   assign pick_d = dreq_v & (~ireq_v | (PRIO_DATA != 0) | ~last_d_q);
   assign expire = (TIMEOUT != 0) && (wdog_q == CNT_W'(WD_LAST));

   always_ff @(posedge ARB_CLK or posedge ARB_RESET) begin
      if (ARB_RESET) begin
         state_q   <= IDLE;
         mem_req_q <= 1'b0;
         we_q      <= 1'b0;
         be_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         irdata_q  <= '0;
         drdata_q  <= '0;
         idone_q   <= 1'b0;
         ddone_q   <= 1'b0;
         last_d_q  <= 1'b1;
         tmo_q     <= 1'b0;
         wdog_q    <= '0;
      end else begin
         state_q   <= state_d;
         mem_req_q <= mem_req_d;
         we_q      <= we_d;
         be_q      <= be_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         irdata_q  <= irdata_d;
         drdata_q  <= drdata_d;
         idone_q   <= idone_d;
         ddone_q   <= ddone_d;
         last_d_q  <= last_d_d;
         tmo_q     <= tmo_d;
         wdog_q    <= wdog_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      be_d     = be_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      idone_d  = 1'b0;
      ddone_d  = 1'b0;
      last_d_d = last_d_q;
      tmo_d    = tmo_q;
      wdog_d   = wdog_q;

      unique case (state_q)
         IDLE: begin
            if (ireq_v || dreq_v) begin
               last_d_d = pick_d;
               wdog_d   = '0;
               if (pick_d) begin
                  state_d = BUSY_D;
                  we_d    = ARB_DWE;
                  be_d    = ARB_DBE;
                  addr_d  = ARB_DADDR;
                  wdata_d = ARB_DWDATA;
               end else begin
                  state_d = BUSY_I;
                  we_d    = 1'b0;
                  be_d    = '1;
                  addr_d  = ARB_IADDR;
                  wdata_d = '0;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            // ACK takes precedence over a simultaneous watchdog expiry.
            if (MEM_ACK) begin
               state_d = IDLE;
               if (state_q == BUSY_I) begin
                  idone_d  = 1'b1;
                  irdata_d = MEM_RDATA;
               end else begin
                  ddone_d = 1'b1;
                  if (!we_q) drdata_d = MEM_RDATA;
               end
            end else if (expire) begin
               state_d = IDLE;
               tmo_d   = 1'b1;
               if (state_q == BUSY_I) begin
                  idone_d  = 1'b1;
                  irdata_d = '1;
               end else begin
                  ddone_d  = 1'b1;
                  drdata_d = '1;
               end
            end else begin
               wdog_d = wdog_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      mem_req_d = (state_d != IDLE);
   end

   assign MEM_REQ     = mem_req_q;
   assign MEM_WE      = we_q;
   assign MEM_BE      = be_q;
   assign MEM_ADDR    = addr_q;
   assign MEM_WDATA   = wdata_q;
   assign ARB_IRDATA  = irdata_q;
   assign ARB_DRDATA  = drdata_q;
   assign ARB_IDONE   = idone_q;
   assign ARB_DDONE   = ddone_q;
   assign ARB_TIMEOUT = tmo_q;
   assign ARB_STALL   = (ARB_IREQ & ~idone_q) | (ARB_DREQ & ~ddone_q);

endmodule
